// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 6502 ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_ASL = 4'd5,
        OP_LSR = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8,
        OP_CMP = 4'd9,
        OP_INC = 4'd10,
        OP_DEC = 4'd11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_ADJUST = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [7:0] BCD_LO       = 8'h06;
    localparam logic [7:0] BCD_HI       = 8'h60;
    localparam logic [7:0] BCD_MAX      = 8'h99;
    localparam logic [7:0] BCD_NEG_LO   = 8'hFA;
    localparam logic [7:0] BCD_NEG_HI   = 8'hA0;
    localparam logic [7:0] BCD_NEG_BOTH = 8'h9A;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sum_sel;
        logic       and_sel;
        logic       xor_sel;
        logic       or_sel;
        logic       sr_sel;
        logic       cin;
    } alu_ctrl_t;

    // First-pass ALU drive for an opcode; undefined opcodes leave the ALU idle.
    function automatic alu_ctrl_t exec_drive(input op_t op, input logic [7:0] a,
                                             input logic [7:0] b, input logic c);
        alu_ctrl_t d;
        d   = '0;
        d.a = a;
        case (op)
            OP_ADC: begin d.sum_sel = 1'b1; d.b = b;     d.cin = c;    end
            OP_SBC: begin d.sum_sel = 1'b1; d.b = ~b;    d.cin = c;    end
            OP_AND: begin d.and_sel = 1'b1; d.b = b;                   end
            OP_ORA: begin d.or_sel  = 1'b1; d.b = b;                   end
            OP_EOR: begin d.xor_sel = 1'b1; d.b = b;                   end
            OP_ASL: begin d.sum_sel = 1'b1; d.b = a;                   end
            OP_ROL: begin d.sum_sel = 1'b1; d.b = a;     d.cin = c;    end
            OP_LSR: begin d.sr_sel  = 1'b1;                            end
            OP_ROR: begin d.sr_sel  = 1'b1;              d.cin = c;    end
            OP_CMP: begin d.sum_sel = 1'b1; d.b = ~b;    d.cin = 1'b1; end
            OP_INC: begin d.sum_sel = 1'b1; d.b = 8'h00; d.cin = 1'b1; end
            OP_DEC: begin d.sum_sel = 1'b1; d.b = 8'hFF;               end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_sequencer_bcd_corr.sv
// Decimal-adjust correction operand and final carry for the second ALU pass.
module bcd_corr
    import alu_seq_pkg::*;
(
    input  logic [7:0] s_i,
    input  logic       c1_i,
    input  logic       h1_i,
    input  logic       is_sub_i,
    output logic [7:0] corr_b_o,
    output logic       final_c_o
);

    always_comb begin
        corr_b_o  = 8'h00;
        final_c_o = c1_i;
        if (is_sub_i) begin
            // Subtraction adds the two's complement of the correction.
            unique case ({!c1_i, !h1_i})
                2'b00: corr_b_o = 8'h00;
                2'b01: corr_b_o = BCD_NEG_LO;
                2'b10: corr_b_o = BCD_NEG_HI;
                2'b11: corr_b_o = BCD_NEG_BOTH;
            endcase
        end else begin
            if (h1_i || (s_i[3:0] > 4'd9)) corr_b_o = corr_b_o | BCD_LO;
            if (c1_i || (s_i > BCD_MAX))   corr_b_o = corr_b_o | BCD_HI;
            final_c_o = c1_i || (s_i > BCD_MAX);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the external 6502 ALU: one op per request, optional BCD pass, owns NVZC.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       decimal_mode,
    output logic       result_valid,
    output logic [7:0] result_data,
    output logic [3:0] flags,
    input  logic       flag_wr,
    input  logic [3:0] flag_wdata,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_sum_sel,
    output logic       alu_and_sel,
    output logic       alu_xor_sel,
    output logic       alu_or_sel,
    output logic       alu_shift_right_sel,
    output logic       alu_carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_half_carry
);

    state_t    state_q;
    op_t       op_q;
    alu_ctrl_t ctrl_q;
    logic [7:0] a_q, s_q, result_q;
    logic [3:0] flags_q, exec_flags_d;
    logic       dec_q, c1_q, v1_q, h1_q, ready_q, valid_q;
    logic [7:0] bcd_s, corr_b;
    logic       bcd_c1, bcd_h1, final_c, needs_adjust, zero_out;
    alu_ctrl_t  adj_ctrl_d;

    // During EXEC the correction is computed from the live first-pass result
    // so the ADJUST drive can be registered; in ADJUST the captured copy is used.
    assign bcd_s  = (state_q == ST_EXEC) ? alu_out        : s_q;
    assign bcd_c1 = (state_q == ST_EXEC) ? alu_carry      : c1_q;
    assign bcd_h1 = (state_q == ST_EXEC) ? alu_half_carry : h1_q;

    bcd_corr u_bcd_corr (
        .s_i      (bcd_s),
        .c1_i     (bcd_c1),
        .h1_i     (bcd_h1),
        .is_sub_i (op_q == OP_SBC),
        .corr_b_o (corr_b),
        .final_c_o(final_c)
    );

    assign needs_adjust = dec_q && ((op_q == OP_ADC) || (op_q == OP_SBC));
    assign zero_out     = (alu_out == 8'h00);

    always_comb begin
        adj_ctrl_d         = '0;
        adj_ctrl_d.a       = alu_out;
        adj_ctrl_d.b       = corr_b;
        adj_ctrl_d.sum_sel = 1'b1;

        exec_flags_d = flags_q;
        case (op_q)
            OP_ADC, OP_SBC:
                exec_flags_d = {alu_out[7], alu_overflow, zero_out, alu_carry};
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin
                exec_flags_d[FLAG_N] = alu_out[7];
                exec_flags_d[FLAG_Z] = zero_out;
            end
            OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_CMP: begin
                exec_flags_d[FLAG_N] = alu_out[7];
                exec_flags_d[FLAG_Z] = zero_out;
                exec_flags_d[FLAG_C] = alu_carry;
            end
            default: exec_flags_d = flags_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADC;
            ctrl_q   <= '0;
            a_q      <= 8'h00;
            s_q      <= 8'h00;
            result_q <= 8'h00;
            flags_q  <= 4'h0;
            dec_q    <= 1'b0;
            c1_q     <= 1'b0;
            v1_q     <= 1'b0;
            h1_q     <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && ready_q) begin
                        op_q    <= op_t'(req_op);
                        a_q     <= req_a;
                        dec_q   <= decimal_mode && DECIMAL_EN;
                        ctrl_q  <= exec_drive(op_t'(req_op), req_a, req_b, flags_q[FLAG_C]);
                        ready_q <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    s_q  <= alu_out;
                    c1_q <= alu_carry;
                    v1_q <= alu_overflow;
                    h1_q <= alu_half_carry;
                    if (needs_adjust) begin
                        ctrl_q  <= adj_ctrl_d;
                        state_q <= ST_ADJUST;
                    end else begin
                        ctrl_q   <= '0;
                        valid_q  <= 1'b1;
                        flags_q  <= exec_flags_d;
                        result_q <= (op_q == OP_CMP || op_q > OP_DEC) ? a_q : alu_out;
                        state_q  <= ST_DONE;
                    end
                end
                ST_ADJUST: begin
                    ctrl_q   <= '0;
                    valid_q  <= 1'b1;
                    result_q <= alu_out;
                    flags_q  <= {alu_out[7], v1_q, zero_out, final_c};
                    state_q  <= ST_DONE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
            // A direct flag load overrides any ALU update on the same edge.
            if (flag_wr) flags_q <= flag_wdata;
        end
    end

    assign req_ready           = ready_q;
    assign result_valid        = valid_q;
    assign result_data         = result_q;
    assign flags               = flags_q;
    assign alu_a               = ctrl_q.a;
    assign alu_b               = ctrl_q.b;
    assign alu_sum_sel         = ctrl_q.sum_sel;
    assign alu_and_sel         = ctrl_q.and_sel;
    assign alu_xor_sel         = ctrl_q.xor_sel;
    assign alu_or_sel          = ctrl_q.or_sel;
    assign alu_shift_right_sel = ctrl_q.sr_sel;
    assign alu_carry_in        = ctrl_q.cin;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU and scoreboards results, flags and latency.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, decimal_mode, result_valid, flag_wr;
    logic [3:0] req_op, flags, flag_wdata;
    logic [7:0] req_a, req_b, result_data, alu_a, alu_b, alu_out;
    logic       alu_sum_sel, alu_and_sel, alu_xor_sel, alu_or_sel, alu_shift_right_sel;
    logic       alu_carry_in, alu_carry, alu_overflow, alu_half_carry;

    alu_sequencer #(.DECIMAL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .decimal_mode(decimal_mode),
        .result_valid(result_valid), .result_data(result_data), .flags(flags),
        .flag_wr(flag_wr), .flag_wdata(flag_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sum_sel(alu_sum_sel), .alu_and_sel(alu_and_sel),
        .alu_xor_sel(alu_xor_sel), .alu_or_sel(alu_or_sel),
        .alu_shift_right_sel(alu_shift_right_sel), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_half_carry(alu_half_carry)
    );

    always #5 clk = ~clk;

    // External 8-bit ALU model
    logic [8:0] sum9;
    logic [4:0] sum5;
    always_comb begin
        sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
        sum5 = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, alu_carry_in};
        alu_out = 8'h00; alu_carry = 1'b0; alu_overflow = 1'b0; alu_half_carry = 1'b0;
        if (alu_sum_sel) begin
            alu_out        = sum9[7:0];
            alu_carry      = sum9[8];
            alu_overflow   = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
            alu_half_carry = sum5[4];
        end else if (alu_and_sel) alu_out = alu_a & alu_b;
        else if (alu_or_sel)      alu_out = alu_a | alu_b;
        else if (alu_xor_sel)     alu_out = alu_a ^ alu_b;
        else if (alu_shift_right_sel) begin
            alu_out   = {alu_carry_in, alu_a[7:1]};
            alu_carry = alu_a[0];
        end
    end

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] model_flags = 4'h0;
    logic [7:0] r, eb, ab;
    logic [3:0] f;
    logic       ec, asum;
    int         lat;

    // Binary-mode reference for the 6502 operations.
    function automatic exp_t ref_bin(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic [3:0] fl);
        exp_t       x;
        logic [8:0] s;
        logic [7:0] t;
        x.flg = fl; x.lat = 2; x.res = a;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, fl[0]};
                x.res = s[7:0];
                x.flg = {s[7], (a[7] == b[7]) && (s[7] != a[7]), s[7:0] == 8'h00, s[8]};
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + {8'd0, fl[0]};
                x.res = s[7:0];
                x.flg = {s[7], (a[7] != b[7]) && (s[7] != a[7]), s[7:0] == 8'h00, s[8]};
            end
            4'd2: begin x.res = a & b;   x.flg = {x.res[7], fl[2], x.res == 8'h00, fl[0]}; end
            4'd3: begin x.res = a | b;   x.flg = {x.res[7], fl[2], x.res == 8'h00, fl[0]}; end
            4'd4: begin x.res = a ^ b;   x.flg = {x.res[7], fl[2], x.res == 8'h00, fl[0]}; end
            4'd5: begin x.res = {a[6:0], 1'b0}; x.flg = {x.res[7], fl[2], x.res == 8'h00, a[7]}; end
            4'd6: begin x.res = {1'b0, a[7:1]}; x.flg = {x.res[7], fl[2], x.res == 8'h00, a[0]}; end
            4'd7: begin x.res = {a[6:0], fl[0]}; x.flg = {x.res[7], fl[2], x.res == 8'h00, a[7]}; end
            4'd8: begin x.res = {fl[0], a[7:1]}; x.flg = {x.res[7], fl[2], x.res == 8'h00, a[0]}; end
            4'd9: begin t = a - b; x.res = a; x.flg = {t[7], fl[2], a == b, a >= b}; end
            4'd10: begin x.res = a + 8'd1; x.flg = {x.res[7], fl[2], x.res == 8'h00, fl[0]}; end
            4'd11: begin x.res = a - 8'd1; x.flg = {x.res[7], fl[2], x.res == 8'h00, fl[0]}; end
            default: begin x.res = a; x.flg = fl; end
        endcase
        return x;
    endfunction

    // Caller is at a negedge; loads flags on the following edge.
    task automatic set_flags(input logic [3:0] v);
        flag_wr = 1'b1; flag_wdata = v;
        @(negedge clk);
        flag_wr = 1'b0;
        model_flags = v;
    endtask

    // Drives one request and returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic dec);
        int waited = 0;
        req_op = op; req_a = a; req_b = b; decimal_mode = dec; req_valid = 1'b1;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Waits (bounded) for result_valid; lat stays -1 on timeout.
    task automatic wait_result(input int fw_cyc, output logic [7:0] rr, output logic [3:0] ff,
                               output int ll, output logic [7:0] exec_b, output logic exec_cin,
                               output logic [7:0] adj_b, output logic adj_sum);
        ll = -1; rr = 8'h00; ff = 4'h0; exec_b = 8'h00; exec_cin = 1'b0; adj_b = 8'h00; adj_sum = 1'b0;
        for (int cyc = 1; cyc <= 8 && ll < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin exec_b = alu_b; exec_cin = alu_carry_in; end
            if (cyc == 2) begin adj_b = alu_b; adj_sum = alu_sum_sel; end
            if (result_valid) begin ll = cyc; rr = result_data; ff = flags; end
            flag_wr = (cyc == fw_cyc);
        end
        flag_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = 8'h00; req_b = 8'h00;
        decimal_mode = 1'b0; flag_wr = 1'b0; flag_wdata = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1 0", req_ready, result_valid);
        end
        vectors++;
        if (result_data !== 8'h00 || flags !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_data: data=%h flags=%h want 00 0", result_data, flags);
        end
        vectors++;
        if ({alu_a, alu_b, alu_sum_sel, alu_and_sel, alu_xor_sel, alu_or_sel,
             alu_shift_right_sel, alu_carry_in} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_alu: a=%h b=%h sel=%b%b%b%b%b cin=%b want all 0", alu_a, alu_b,
                     alu_sum_sel, alu_and_sel, alu_xor_sel, alu_or_sel, alu_shift_right_sel, alu_carry_in);
        end
    endtask

    task automatic test_adc_binary();
        set_flags(4'h0);
        sb.push_back('{res: 8'hA0, flg: 4'hC, lat: 2});
        issue(4'd0, 8'h50, 8'h50, 1'b0);
        wait_result(-1, r, f, lat, eb, ec, ab, asum);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat || r !== e.res || f !== e.flg) begin
            miscompares++;
            $display("FAIL adc_bin: lat=%0d res=%h flags=%h want %0d %h %h", lat, r, f, e.lat, e.res, e.flg);
        end
        vectors++;
        if (alu_sum_sel !== 1'b0 || alu_a !== 8'h00) begin
            miscompares++;
            $display("FAIL done_alu_idle: sum=%b a=%h want 0 00", alu_sum_sel, alu_a);
        end
        @(negedge clk);
        vectors++;
        if (result_valid !== 1'b0 || req_ready !== 1'b1 || result_data !== 8'hA0) begin
            miscompares++;
            $display("FAIL pulse_hold: valid=%b ready=%b data=%h want 0 1 a0", result_valid, req_ready, result_data);
        end
        model_flags = e.flg;
    endtask

    task automatic test_adc_decimal();
        set_flags(4'h0);
        sb.push_back('{res: 8'h47, flg: 4'h0, lat: 3});
        issue(4'd0, 8'h19, 8'h28, 1'b1);
        wait_result(-1, r, f, lat, eb, ec, ab, asum);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat || r !== e.res || f !== e.flg) begin
            miscompares++;
            $display("FAIL adc_dec: lat=%0d res=%h flags=%h want %0d %h %h", lat, r, f, e.lat, e.res, e.flg);
        end
        vectors++;
        if (ab !== 8'h06 || asum !== 1'b1) begin
            miscompares++;
            $display("FAIL adc_dec_adjust: alu_b=%h sum=%b want 06 1", ab, asum);
        end
        model_flags = e.flg;
    endtask

    task automatic test_sbc_decimal();
        set_flags(4'h1);
        sb.push_back('{res: 8'h29, flg: 4'h1, lat: 3});
        issue(4'd1, 8'h42, 8'h13, 1'b1);
        wait_result(-1, r, f, lat, eb, ec, ab, asum);
        e = sb.pop_front();
        vectors++;
        if (eb !== 8'hEC || ec !== 1'b1) begin
            miscompares++;
            $display("FAIL sbc_dec_exec: alu_b=%h cin=%b want ec 1", eb, ec);
        end
        vectors++;
        if (ab !== 8'hFA) begin
            miscompares++;
            $display("FAIL sbc_dec_adjust: alu_b=%h want fa", ab);
        end
        vectors++;
        if (lat !== e.lat || r !== e.res || f !== e.flg) begin
            miscompares++;
            $display("FAIL sbc_dec: lat=%0d res=%h flags=%h want %0d %h %h", lat, r, f, e.lat, e.res, e.flg);
        end
        model_flags = e.flg;
    endtask

    task automatic test_cmp();
        set_flags(4'h4);
        sb.push_back('{res: 8'h10, flg: 4'hC, lat: 2});
        issue(4'd9, 8'h10, 8'h20, 1'b0);
        wait_result(-1, r, f, lat, eb, ec, ab, asum);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat || r !== e.res || f !== e.flg) begin
            miscompares++;
            $display("FAIL cmp: lat=%0d res=%h flags=%h want %0d %h %h", lat, r, f, e.lat, e.res, e.flg);
        end
        model_flags = e.flg;
    endtask

    task automatic test_ror_flag_wr();
        set_flags(4'h1);
        sb.push_back('{res: 8'h80, flg: 4'h9, lat: 2});
        issue(4'd8, 8'h01, 8'h00, 1'b0);
        wait_result(-1, r, f, lat, eb, ec, ab, asum);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat || r !== e.res || f !== e.flg) begin
            miscompares++;
            $display("FAIL ror: lat=%0d res=%h flags=%h want %0d %h %h", lat, r, f, e.lat, e.res, e.flg);
        end
        // ADC would set N and V here; the flag load on the same edge must win.
        flag_wdata = 4'h0;
        sb.push_back('{res: 8'hA1, flg: 4'h0, lat: 2});
        issue(4'd0, 8'h50, 8'h50, 1'b0);
        wait_result(1, r, f, lat, eb, ec, ab, asum);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat || r !== e.res || f !== e.flg) begin
            miscompares++;
            $display("FAIL flag_wr_wins: lat=%0d res=%h flags=%h want %0d %h %h", lat, r, f, e.lat, e.res, e.flg);
        end
        model_flags = 4'h0;
    endtask

    task automatic test_rst_mid();
        set_flags(4'hF);
        issue(4'd0, 8'h19, 8'h28, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (result_valid !== 1'b0 || flags !== 4'h0 || req_ready !== 1'b1 || alu_sum_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: valid=%b flags=%h ready=%b sum=%b want 0 0 1 0",
                     result_valid, flags, req_ready, alu_sum_sel);
        end
        @(negedge clk);
        vectors++;
        if (result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_pulse: valid=%b want 0", result_valid);
        end
        rst = 1'b0;
        model_flags = 4'h0;
        sb.push_back('{res: 8'h02, flg: 4'h0, lat: 2});
        issue(4'd0, 8'h01, 8'h01, 1'b0);
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL post_rst_accept: ready=%b want 0", req_ready);
        end
        wait_result(-1, r, f, lat, eb, ec, ab, asum);
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat || r !== e.res || f !== e.flg) begin
            miscompares++;
            $display("FAIL post_rst_op: lat=%0d res=%h flags=%h want %0d %h %h", lat, r, f, e.lat, e.res, e.flg);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [12] = '{4'd10, 4'd11, 4'd5, 4'd6, 4'd7, 4'd2, 4'd3, 4'd4,
                                 4'd13, 4'd1, 4'd9, 4'd0};
        logic [7:0] as_ [12] = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'h40, 8'hF0, 8'h00, 8'hAA,
                                 8'h5A, 8'h80, 8'h33, 8'h7F};
        logic [7:0] bs_ [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hAA,
                                 8'h11, 8'h01, 8'h33, 8'h01};
        set_flags(4'h0);
        for (int i = 0; i < 12; i++) begin
            sb.push_back(ref_bin(ops[i], as_[i], bs_[i], model_flags));
            issue(ops[i], as_[i], bs_[i], 1'b0);
            wait_result(-1, r, f, lat, eb, ec, ab, asum);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat || r !== e.res || f !== e.flg) begin
                miscompares++;
                $display("FAIL b2b[%0d] op=%0d: lat=%0d res=%h flags=%h want %0d %h %h",
                         i, ops[i], lat, r, f, e.lat, e.res, e.flg);
            end
            model_flags = e.flg;
        end
    endtask

    initial begin
        test_reset();
        test_adc_binary();
        test_adc_decimal();
        test_sbc_decimal();
        test_cmp();
        test_ror_flag_wr();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control block that sequences the 8-bit combinational ALU for the 6502 core. It accepts one operation per request and drives the ALU select, operand and carry lines. It runs a second ALU pass for BCD adjustment when decimal mode is active. It owns the N/V/Z/C status flags and returns a registered result to the execute stage.

## Interface
- `DECIMAL_EN`, default 1: 1 = BCD passes enabled; 0 = `decimal_mode` is ignored.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 4: `op_t` opcode (ADC=0, SBC=1, AND=2, ORA=3, EOR=4, ASL=5, LSR=6, ROL=7, ROR=8, CMP=9, INC=10, DEC=11).
- `req_a`, `req_b` in 8: operands.
- `decimal_mode` in 1: D flag, sampled at accept.
- `result_valid` out 1: one-cycle pulse.
- `result_data` out 8: result, held until next accept.
- `flags` out 4: {N,V,Z,C} register.
- `flag_wr` in 1, `flag_wdata` in 4: direct flag load (PLP/SEC/CLC/CLV).
- `alu_a`, `alu_b` out 8: ALU operands.
- `alu_sum_sel`, `alu_and_sel`, `alu_xor_sel`, `alu_or_sel`, `alu_shift_right_sel`, `alu_carry_in` out 1 each: ALU controls.
- `alu_out` in 8, `alu_carry`, `alu_overflow`, `alu_half_carry` in 1: ALU results, same-cycle combinational.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on accept (`req_valid && req_ready`). Operands, op, `decimal_mode` and a snapshot of C are registered.
  - EXEC → ADJUST if (ADC|SBC) && decimal && `DECIMAL_EN`; otherwise EXEC → DONE.
  - ADJUST → DONE.
  - DONE → IDLE.
- ALU drive in EXEC, per op:
  - ADC: sum, a, b, cin=C.
  - SBC: sum, a, ~b, cin=C.
  - AND, ORA, EOR: the matching select.
  - ASL: sum, a, a, cin=0.
  - ROL: as ASL, cin=C.
  - LSR: shift_right, cin=0. ALU result is {cin,a[7:1]}; carry = a[0].
  - ROR: as LSR, cin=C.
  - CMP: sum, a, ~b, cin=1.
  - INC: sum, a, 0x00, cin=1.
  - DEC: sum, a, 0xFF, cin=0.
- In IDLE and DONE all ALU outputs are 0.
- EXEC captures S = `alu_out`, C1, V1, H1.
- ADJUST, both directions: `alu_a`=S, sum, cin=0.
  - ADC: `alu_b` = (H1 or S[3:0]>9 ? 0x06 : 0) | (C1 or S>0x99 ? 0x60 : 0). Final C = C1 | (S>0x99).
  - SBC: corr = (!H1 ? 0x06 : 0) | (!C1 ? 0x60 : 0); `alu_b` = two's complement of corr (0x00/0xFA/0xA0/0x9A). Final C = C1.
- Flag update at the EXEC→DONE or ADJUST→DONE edge:
  - ADC, SBC: N, V, Z, C. V = V1. N/Z come from the final result.
  - AND, ORA, EOR, INC, DEC: N, Z only.
  - Shifts and CMP: N, Z, C.
- `result_data`: CMP returns `req_a` unchanged; all other ops return the final ALU result.
- `flag_wr` writes all four flags at the next edge. It wins over a same-edge ALU update.
- `req_valid` while not ready is ignored; no queueing.
- Undefined `req_op` (12–15) completes as a NOP: result = a, flags unchanged.

## Timing
- Reset values: IDLE, `req_ready`=1, `result_valid`=0, `result_data`=0x00, `flags`=0x0, all ALU outputs 0.
- Binary ops: accept on edge t; EXEC in cycle t+1; `result_valid` high in cycle t+2. Decimal ops: `result_valid` high in cycle t+3.
- `flags` reflect the new values in the same cycle `result_valid` is high.
- Throughput: one op per 3 cycles binary, 4 cycles decimal.
- Reset asserted mid-operation: immediate return to IDLE with reset values; no `result_valid` pulse for the aborted op.

## Structure
- `alu_seq_pkg` holds:
  - `op_t` enum and `state_t` enum;
  - flag bit indices N=3, V=2, Z=1, C=0;
  - BCD constants 0x06, 0x60, 0x99 and the 0xFA/0xA0/0x9A negations.
- One combinational sub-module, `bcd_corr`, takes (S, C1, H1, is_sub) and returns (corr_b, final_c).
- The ALU itself stays external.

## Test plan
- ADC binary, a=0x50, b=0x50, C=0 → `result_valid` at t+2; result 0xA0; N=1 V=1 Z=0 C=0.
- ADC decimal, a=0x19, b=0x28, C=0 → `result_valid` at t+3; ADJUST drives `alu_b`=0x06; result 0x47; C=0.
- SBC decimal, a=0x42, b=0x13, C=1 → EXEC S=0x2F, H1=0; ADJUST `alu_b`=0xFA; result 0x29; C=1.
- CMP, a=0x10, b=0x20, V preset 1 → `result_data`=0x10; N=1 Z=0 C=0; V stays 1.
- ROR, a=0x01, C=1 → result 0x80; C=1 N=1. `flag_wr`=1 with `flag_wdata`=0x0 on the DONE edge of any op → flags=0x0.
- Assert `rst` during EXEC of a decimal ADC → no `result_valid`, flags=0x0, `req_ready`=1. A request in the first post-reset cycle is accepted.
